// File: rtl/wireframe_framebuffer_pkg.sv
// Shared types and default geometry for the wireframe frame store.
// Geometry macros may be supplied by the build; these defaults describe an 8x4 frame.
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef HEIGHT
`define HEIGHT 4
`endif
`ifndef WIREFRAME_ADDR_SIZE
`define WIREFRAME_ADDR_SIZE 5
`endif
`ifndef WF_BG
`define WF_BG 1'b1
`endif

package wireframe_framebuffer_pkg;

  localparam int   FB_WIDTH  = `WIDTH;
  localparam int   FB_HEIGHT = `HEIGHT;
  localparam int   FB_ADDR_W = `WIREFRAME_ADDR_SIZE;
  localparam logic FB_BG     = `WF_BG;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SCAN  = 2'd2
  } fb_state_t;

  typedef struct packed {
    logic data;
    logic eol;
    logic eof;
  } fb_pix_t;

  // RAM index width; a single-cell store still needs a 1-bit index.
  function automatic int fb_index_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wireframe_framebuffer_if.sv
// Pixel write port, control/status and scan-out stream of the frame store.
interface wireframe_framebuffer_if
  import wireframe_framebuffer_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W
);

  logic              write_en;
  logic              wf_data;
  logic [ADDR_W-1:0] addr;
  logic              clear;
  logic              scan_start;
  logic              busy;
  logic              clear_done;
  logic              scan_done;
  logic              wr_dropped;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_data;
  logic              pix_eol;
  logic              pix_eof;

  modport master (
    output write_en, wf_data, addr, clear, scan_start, pix_ready,
    input  busy, clear_done, scan_done, wr_dropped,
           pix_valid, pix_data, pix_eol, pix_eof
  );

  modport slave (
    input  write_en, wf_data, addr, clear, scan_start, pix_ready,
    output busy, clear_done, scan_done, wr_dropped,
           pix_valid, pix_data, pix_eol, pix_eof
  );

endinterface

// File: rtl/wireframe_framebuffer_ram.sv
// 1-write/1-read synchronous bit RAM; a same-cycle read and write of one cell
// returns the old value.
module wf_bitmap_ram
  import wireframe_framebuffer_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int IDX_W = fb_index_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic             wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic             rdata
);

  logic mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/wireframe_framebuffer.sv
// Frame store between rasterizer and display: absorbs pixel writes, clears to
// background on request and streams the frame out row-major over valid/ready.
module wireframe_framebuffer
  import wireframe_framebuffer_pkg::*;
#(
  parameter int   WIDTH  = FB_WIDTH,
  parameter int   HEIGHT = FB_HEIGHT,
  parameter int   ADDR_W = FB_ADDR_W,
  parameter logic BG     = FB_BG
) (
  input logic                    clk,
  input logic                    rst,
  wireframe_framebuffer_if.slave fb
);

  localparam int                N         = WIDTH * HEIGHT;
  localparam int                IDX_W     = fb_index_w(N);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(WIDTH - 1);

  fb_state_t         state, state_next;
  logic [ADDR_W-1:0] fill_cnt, rd_cnt, col_cnt;
  logic              rd_all, rd_pending, pend_eol, pend_eof;
  fb_pix_t           slot0, slot1, slot0_next, slot1_next, head, incoming;
  logic [1:0]        buf_count, buf_count_next;
  logic [2:0]        occ_after;
  logic              pix_valid, pop, issue;
  logic              addr_in_range, ext_we, ram_we, ram_wdata, ram_rdata;
  logic [IDX_W-1:0]  ram_waddr;
  logic              clear_done_q, scan_done_q, wr_dropped_q;

  assign addr_in_range = int'(fb.addr) < N;
  assign ext_we        = fb.write_en && addr_in_range && (state != CLEAR);

  // The fill counter owns the write port for the whole clear.
  assign ram_we    = (state == CLEAR) || ext_we;
  assign ram_waddr = (state == CLEAR) ? fill_cnt[IDX_W-1:0] : fb.addr[IDX_W-1:0];
  assign ram_wdata = (state == CLEAR) ? BG : fb.wf_data;

  wf_bitmap_ram #(
    .DEPTH (N),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (issue),
    .raddr (rd_cnt[IDX_W-1:0]),
    .rdata (ram_rdata)
  );

  // A returning read is presented directly while the skid buffer is empty, and
  // parked in the buffer if it is not taken, so the output never moves while stalled.
  assign incoming  = '{data: ram_rdata, eol: pend_eol, eof: pend_eof};
  assign head      = (buf_count != 2'd0) ? slot0 : incoming;
  assign pix_valid = (buf_count != 2'd0) || rd_pending;
  assign pop       = pix_valid && fb.pix_ready;
  assign occ_after = 3'(buf_count) + 3'(rd_pending) - 3'(pop);
  assign issue     = (state == SCAN) && !rd_all && (occ_after < 3'd2);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (fb.clear) begin
          state_next = CLEAR;
        end else if (fb.scan_start) begin
          state_next = SCAN;
        end
      end
      CLEAR: begin
        if (fill_cnt == LAST_ADDR) begin
          state_next = IDLE;
        end
      end
      SCAN: begin
        if (pop && head.eof) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    slot0_next     = slot0;
    slot1_next     = slot1;
    buf_count_next = buf_count;
    if (buf_count != 2'd0) begin
      if (pop) begin
        slot0_next     = slot1;
        buf_count_next = buf_count - 2'd1;
      end
      if (rd_pending) begin
        if (buf_count_next == 2'd0) begin
          slot0_next = incoming;
        end else begin
          slot1_next = incoming;
        end
        buf_count_next = buf_count_next + 2'd1;
      end
    end else if (rd_pending && !pop) begin
      slot0_next     = incoming;
      buf_count_next = 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt     <= '0;
      clear_done_q <= 1'b0;
      scan_done_q  <= 1'b0;
      wr_dropped_q <= 1'b0;
    end else begin
      fill_cnt     <= (state == CLEAR) ? fill_cnt + ADDR_W'(1) : '0;
      clear_done_q <= (state == CLEAR) && (fill_cnt == LAST_ADDR);
      scan_done_q  <= (state == SCAN) && pop && head.eof;
      if (fb.write_en && ((state == CLEAR) || !addr_in_range)) begin
        wr_dropped_q <= 1'b1;
      end
    end
  end

  // Row/frame markers are computed when the read is issued and travel with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt     <= '0;
      col_cnt    <= '0;
      rd_all     <= 1'b0;
      rd_pending <= 1'b0;
      pend_eol   <= 1'b0;
      pend_eof   <= 1'b0;
      slot0      <= '0;
      slot1      <= '0;
      buf_count  <= 2'd0;
    end else begin
      rd_pending <= issue;
      slot0      <= slot0_next;
      slot1      <= slot1_next;
      buf_count  <= buf_count_next;
      if (state != SCAN) begin
        rd_cnt  <= '0;
        col_cnt <= '0;
        rd_all  <= 1'b0;
      end else if (issue) begin
        rd_cnt   <= rd_cnt + ADDR_W'(1);
        col_cnt  <= (col_cnt == LAST_COL) ? '0 : col_cnt + ADDR_W'(1);
        pend_eol <= (col_cnt == LAST_COL);
        pend_eof <= (rd_cnt == LAST_ADDR);
        rd_all   <= (rd_cnt == LAST_ADDR);
      end
    end
  end

  assign fb.busy       = (state != IDLE);
  assign fb.clear_done = clear_done_q;
  assign fb.scan_done  = scan_done_q;
  assign fb.wr_dropped = wr_dropped_q;
  assign fb.pix_valid  = pix_valid;
  assign fb.pix_data   = pix_valid && head.data;
  assign fb.pix_eol    = pix_valid && head.eol;
  assign fb.pix_eof    = pix_valid && head.eof;

endmodule

// File: tb/tb_wireframe_framebuffer.sv
// Self-checking bench for wireframe_framebuffer on an 8x4 frame: table of
// clear/write/scan scenarios plus hand-written drop and mid-scan reset sequences.
module tb_wireframe_framebuffer;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int AW = 6;

  logic tb_clk = 1'b0;
  logic rst;

  always #5 tb_clk = ~tb_clk;

  wireframe_framebuffer_if #(.ADDR_W(AW)) fb ();

  wireframe_framebuffer #(
    .WIDTH  (W),
    .HEIGHT (H),
    .ADDR_W (AW),
    .BG     (1'b1)
  ) dut (
    .clk (tb_clk),
    .rst (rst),
    .fb  (fb)
  );

  typedef struct {
    int         z0;
    int         z1;
    int         z2;
    logic [3:0] ready_pat;
    logic       exp_dropped;
  } scan_vec_t;

  scan_vec_t  vecs[4];
  logic       model_img[N];
  logic [2:0] exp_q[$];
  int         n_vec  = 0;
  int         n_miss = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] all_outputs();
    return {fb.busy, fb.clear_done, fb.scan_done, fb.wr_dropped,
            fb.pix_valid, fb.pix_data, fb.pix_eol, fb.pix_eof};
  endfunction

  task automatic write_pixel(input int a, input logic d, input logic update_model);
    fb.write_en = 1'b1;
    fb.addr     = AW'(a);
    fb.wf_data  = d;
    @(negedge tb_clk);
    fb.write_en = 1'b0;
    if (update_model && a < N) model_img[a] = d;
  endtask

  // Clear with busy/clear_done timing checks; optionally write addr inj_addr in clear cycle 3.
  task automatic do_clear(input int inj_addr);
    int cnt;
    fb.clear = 1'b1;
    @(negedge tb_clk);
    fb.clear = 1'b0;
    cnt = 0;
    while (fb.busy && cnt < 100) begin
      cnt++;
      if (inj_addr >= 0 && cnt == 3) begin
        fb.write_en = 1'b1;
        fb.addr     = AW'(inj_addr);
        fb.wf_data  = 1'b0;
      end else begin
        fb.write_en = 1'b0;
      end
      @(negedge tb_clk);
    end
    fb.write_en = 1'b0;
    check_output("clear_busy_cycles", cnt, N);
    check_output("clear_done_pulse", {fb.clear_done, fb.busy}, 2'b10);
    @(negedge tb_clk);
    check_output("clear_done_low", fb.clear_done, 1'b0);
    for (int i = 0; i < N; i++) model_img[i] = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [3:0] pat, input int limit);
    int         cyc, hs, first_v, last_hs;
    logic       held, rdy;
    logic [3:0] prev, cur;
    logic [2:0] exp;
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back({model_img[i], (i % W) == W - 1, i == N - 1});
    fb.scan_start = 1'b1;
    fb.pix_ready  = 1'b0;
    @(negedge tb_clk);
    fb.scan_start = 1'b0;
    cyc = 1; hs = 0; first_v = 0; last_hs = 0; held = 1'b0; prev = '0;
    check_output("valid_cycle1", fb.pix_valid, 1'b0);
    while (hs < limit && cyc < 400) begin
      rdy          = pat[3 - (cyc % 4)];
      fb.pix_ready = rdy;
      cur = {fb.pix_valid, fb.pix_data, fb.pix_eol, fb.pix_eof};
      if (held) check_output("hold_stable", cur, prev);
      if (fb.pix_valid && first_v == 0) first_v = cyc;
      if (fb.pix_valid && rdy) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("[TB] FAIL extra_pixel: got pixel %0d, expected none", hs);
        end else begin
          exp = exp_q.pop_front();
          check_output($sformatf("pixel%0d", hs), cur[2:0], exp);
        end
        hs++;
        last_hs = cyc;
        held    = 1'b0;
      end else begin
        held = fb.pix_valid;
      end
      prev = cur;
      @(negedge tb_clk);
      cyc++;
    end
    check_output("handshakes", hs, limit);
    if (limit == N) begin
      if (pat == 4'b1111) begin
        check_output("first_valid_cycle", first_v, 2);
        check_output("last_hs_cycle", last_hs, N + 1);
      end
      check_output("scan_done_pulse", {fb.scan_done, fb.busy}, 2'b10);
      check_output("queue_empty", exp_q.size(), 0);
      fb.pix_ready = 1'b0;
      @(negedge tb_clk);
      check_output("scan_done_low", fb.scan_done, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{z0: -1, z1: -1, z2: -1, ready_pat: 4'b1111, exp_dropped: 1'b0};
    vecs[1] = '{z0: 0,  z1: 9,  z2: 31, ready_pat: 4'b1111, exp_dropped: 1'b0};
    vecs[2] = '{z0: 0,  z1: 9,  z2: 31, ready_pat: 4'b1001, exp_dropped: 1'b0};
    vecs[3] = '{z0: 3,  z1: 4,  z2: 30, ready_pat: 4'b0110, exp_dropped: 1'b0};

    rst           = 1'b1;
    fb.write_en   = 1'b0;
    fb.wf_data    = 1'b0;
    fb.addr       = '0;
    fb.clear      = 1'b0;
    fb.scan_start = 1'b0;
    fb.pix_ready  = 1'b0;
    repeat (2) @(negedge tb_clk);
    check_output("reset_outputs", all_outputs(), 8'h00);
    rst = 1'b0;
    repeat (3) @(negedge tb_clk);
    check_output("idle_busy", fb.busy, 1'b0);

    for (int v = 0; v < 4; v++) begin
      do_clear(-1);
      if (vecs[v].z0 >= 0) write_pixel(vecs[v].z0, 1'b0, 1'b1);
      if (vecs[v].z1 >= 0) write_pixel(vecs[v].z1, 1'b0, 1'b1);
      if (vecs[v].z2 >= 0) write_pixel(vecs[v].z2, 1'b0, 1'b1);
      apply_stimulus(vecs[v].ready_pat, N);
      check_output($sformatf("wr_dropped_vec%0d", v), fb.wr_dropped, vecs[v].exp_dropped);
    end

    // Out-of-range write in IDLE is dropped and sticks until reset.
    write_pixel(32, 1'b0, 1'b0);
    check_output("drop_out_of_range", fb.wr_dropped, 1'b1);
    repeat (2) @(negedge tb_clk);
    check_output("drop_sticky", fb.wr_dropped, 1'b1);
    rst = 1'b1;
    @(negedge tb_clk);
    rst = 1'b0;
    check_output("reset_clears_drop", all_outputs(), 8'h00);

    // Write during clear is dropped; pixel 5 must still read background.
    do_clear(5);
    check_output("drop_during_clear", fb.wr_dropped, 1'b1);
    apply_stimulus(4'b1111, N);

    // Reset after the 10th handshake, then a fresh scan restarts at pixel 0.
    apply_stimulus(4'b1111, 10);
    rst = 1'b1;
    @(negedge tb_clk);
    check_output("midscan_reset_valid_busy", {fb.pix_valid, fb.busy}, 2'b00);
    check_output("midscan_reset_outputs", all_outputs(), 8'h00);
    rst = 1'b0;
    exp_q.delete();
    @(negedge tb_clk);
    do_clear(-1);
    write_pixel(2, 1'b0, 1'b1);
    apply_stimulus(4'b1111, N);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
